// File: rtl/vx_smem_responder.sv
// Banked shared-memory responder: slave end of the LSU dcache request/response bundle.
// Optional SMEM_DUP_MERGE_EN grants identical-address reads in one bank together. NUM_REQS must be >= 2.
module vx_smem_responder #(
  parameter int NUM_REQS       = 4,
  parameter int SIZE           = 4096,
  parameter int TAG_WIDTH      = 8,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic                          clk,
  input  logic                          reset,  // asynchronous, active-low
  input  logic [NUM_REQS-1:0]           req_valid,
  input  logic [NUM_REQS-1:0]           req_rw,
  input  logic [NUM_REQS*30-1:0]        req_addr,
  input  logic [NUM_REQS*4-1:0]         req_byteen,
  input  logic [NUM_REQS*32-1:0]        req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]           req_ready,
  output logic                          rsp_valid,
  output logic [NUM_REQS-1:0]           rsp_tmask,
  output logic [NUM_REQS*32-1:0]        rsp_data,
  output logic [TAG_WIDTH-1:0]          rsp_tag,
  input  logic                          rsp_ready
);
  localparam int BANK_BITS  = $clog2(NUM_REQS);
  localparam int BANK_WORDS = SIZE / (4 * NUM_REQS);
  localparam int OFF_BITS   = $clog2(BANK_WORDS);
  localparam int HI_BITS    = 30 - BANK_BITS - OFF_BITS;
  localparam int CW         = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int PW         = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;

  logic [BANK_BITS-1:0] lane_bank [NUM_REQS];
  logic [OFF_BITS-1:0]  lane_off  [NUM_REQS];
  logic [TAG_WIDTH-1:0] lane_tag  [NUM_REQS];
  logic [TAG_WIDTH-1:0] lead_tag;
  logic [NUM_REQS-1:0]  cand, first, grant, fire, rd_fire;
  logic                 rd_accept, unused_addr_hi;
  logic [CW-1:0]        credits;

  // Lane decode, lead tag and per-bank arbitration.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    lead_tag       = '0;
    unused_addr_hi = 1'b0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      lane_bank[i] = req_addr[i*30 +: BANK_BITS];
      lane_off[i]  = req_addr[i*30+BANK_BITS +: OFF_BITS];
      lane_tag[i]  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
      unused_addr_hi = unused_addr_hi ^ (^req_addr[i*30+BANK_BITS+OFF_BITS +: HI_BITS]);
      if (req_valid[i]) lead_tag = lane_tag[i];
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      cand[i]  = req_valid[i] && (lane_tag[i] == lead_tag);
      first[i] = cand[i];
      for (int j = 0; j < i; j++)
        if (cand[j] && (lane_bank[j] == lane_bank[i])) first[i] = 1'b0;
    end
    grant = first;
`ifdef SMEM_DUP_MERGE_EN
    for (int i = 0; i < NUM_REQS; i++)
      for (int j = 0; j < i; j++)
        if (first[j] && cand[i] && !req_rw[j] && !req_rw[i] &&
            (lane_bank[j] == lane_bank[i]) && (lane_off[j] == lane_off[i]))
          grant[i] = 1'b1;
`endif
  end

  // Reads wait for a response credit; writes never do.
  assign req_ready = reset ? (grant & (req_rw | {NUM_REQS{credits != '0}})) : '0;
  assign fire      = req_valid & req_ready;
  assign rd_fire   = fire & ~req_rw;
  assign rd_accept = |rd_fire;

  logic                 bank_we    [NUM_REQS];
  logic                 bank_re    [NUM_REQS];
  logic [3:0]           bank_be    [NUM_REQS];
  logic [31:0]          bank_wdata [NUM_REQS];
  logic [OFF_BITS-1:0]  bank_off   [NUM_REQS];
  logic [31:0]          bank_rdata [NUM_REQS];
  logic [31:0]          mem        [NUM_REQS][BANK_WORDS];

  // Route each bank's winning lane; scanning high to low leaves the lowest lane in control.
  always_comb begin
    for (int b = 0; b < NUM_REQS; b++) begin
      bank_we[b] = 1'b0;  bank_re[b] = 1'b0;  bank_be[b] = '0;
      bank_wdata[b] = '0; bank_off[b] = '0;
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
        if (fire[i] && (lane_bank[i] == BANK_BITS'(b))) begin
          bank_we[b]    = req_rw[i];
          bank_re[b]    = !req_rw[i];
          bank_be[b]    = req_byteen[i*4 +: 4];
          bank_wdata[b] = req_data[i*32 +: 32];
          bank_off[b]   = lane_off[i];
        end
      end
    end
  end

  // NOTE: storage arrays carry no reset; their contents survive reset and only control state is cleared.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_REQS; b++) begin
      if (bank_we[b])
        for (int k = 0; k < 4; k++)
          if (bank_be[b][k]) mem[b][bank_off[b]][k*8 +: 8] <= bank_wdata[b][k*8 +: 8];
      if (bank_re[b]) bank_rdata[b] <= mem[b][bank_off[b]];
    end
  end

  logic                 s1_valid;
  logic [NUM_REQS-1:0]  s1_tmask;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic [BANK_BITS-1:0] s1_bank [NUM_REQS];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_tmask <= '0;
      s1_tag   <= '0;
      for (int i = 0; i < NUM_REQS; i++) s1_bank[i] <= '0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) begin
        s1_tmask <= rd_fire;
        s1_tag   <= lead_tag;
        for (int i = 0; i < NUM_REQS; i++) s1_bank[i] <= lane_bank[i];
      end
    end
  end

  logic [NUM_REQS*32-1:0] push_data;
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++)
      push_data[i*32 +: 32] = s1_tmask[i] ? bank_rdata[s1_bank[i]] : 32'h0;
  end

  logic [NUM_REQS-1:0]    q_tmask [RSP_QUEUE_SIZE];
  logic [NUM_REQS*32-1:0] q_data  [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]   q_tag   [RSP_QUEUE_SIZE];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count;
  logic                   pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(RSP_QUEUE_SIZE - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop       = rsp_valid && rsp_ready;
  assign rsp_valid = (count != '0);
  assign rsp_tmask = rsp_valid ? q_tmask[rd_ptr] : '0;
  assign rsp_data  = rsp_valid ? q_data[rd_ptr]  : '0;
  assign rsp_tag   = rsp_valid ? q_tag[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      q_tmask[wr_ptr] <= s1_tmask;
      q_data[wr_ptr]  <= push_data;
      q_tag[wr_ptr]   <= s1_tag;
    end
  end

  // Credits count free queue slots including reads still in the bank stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      credits <= CW'(RSP_QUEUE_SIZE);
    end else begin
      if (s1_valid) wr_ptr <= next_ptr(wr_ptr);
      if (pop)      rd_ptr <= next_ptr(rd_ptr);
      case ({s1_valid, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      case ({rd_accept, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!(|(req_ready & ~req_valid))) else $error("lane ready without req_valid");
      assert (!(rd_accept && (credits == '0))) else $error("response credit underflow");
    end
  end
`endif
endmodule
